tagged_mem: RTL and testbench

- Behavioural-plus-synthesizable main-memory model behind the processor's memory bus.
- Accepts one load or store command per cycle and returns a nonzero transaction tag immediately.
- Completes loads a fixed LATENCY cycles later by presenting the data together with the matching tag.
- Models a split-transaction, fixed-latency DRAM for cache/fetch/LSU integration.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/mem_tag_alloc.sv | 50 +++++
 rtl/tagged_mem.sv | 102 ++++++++++
 tb/tb_tagged_mem.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: command encoding, tag and bus widths.
package mem_bus_pkg;

    localparam int TAG_W    = 4;
    localparam int NUM_TAGS = 15;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    // Encoding 3 is reserved and behaves like BUS_NONE.
    function automatic logic is_cmd_active(input logic [1:0] cmd);
        return (cmd == BUS_LOAD) || (cmd == BUS_STORE);
    endfunction

endpackage

// File: rtl/mem_tag_alloc.sv
// Transaction tag allocator: lowest-free-tag encoder over a busy vector.
// Bit i of the busy vector tracks tag i+1; tag 0 means "no tag".
module mem_tag_alloc
    import mem_bus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_i,      // active command presented this cycle
    input  logic             set_i,      // load accepted with tag_o this cycle
    input  logic [TAG_W-1:0] clr_tag_i,  // tag completing this cycle, 0 = none
    output logic [TAG_W-1:0] tag_o
);

    logic [NUM_TAGS-1:0] busy_q;
    logic [NUM_TAGS-1:0] busy_d;

    // Pick the lowest-numbered free tag; scanning downward lets the lowest win.
    always_comb begin
        tag_o = '0;
        if (req_i) begin
            for (int i = NUM_TAGS - 1; i >= 0; i--) begin
                if (!busy_q[i]) begin
                    tag_o = TAG_W'(i + 1);
                end
            end
        end
    end

    // Busy next-state: clear the completing tag, then mark a newly issued load tag.
    // The two never collide because a completing tag is still busy when tags are picked.
    always_comb begin
        busy_d = busy_q;
        if (clr_tag_i != '0) begin
            busy_d[clr_tag_i - TAG_W'(1)] = 1'b0;
        end
        if (set_i && (tag_o != '0)) begin
            busy_d[tag_o - TAG_W'(1)] = 1'b1;
        end
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/tagged_mem.sv
// Split-transaction fixed-latency main memory. Commands get a tag at once;
// loads return their snapshot data with the same tag LATENCY cycles later.
module tagged_mem
    import mem_bus_pkg::*;
#(
    parameter int LATENCY   = 10,
    parameter int MEM_WORDS = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] proc2mem_addr,
    input  logic [DATA_W-1:0] proc2mem_data,
    input  logic [1:0]        proc2mem_command,
    output logic [TAG_W-1:0]  mem2proc_response,
    output logic [DATA_W-1:0] mem2proc_data,
    output logic [TAG_W-1:0]  mem2proc_tag
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    logic [TAG_W-1:0]  dl_tag_q  [LATENCY];
    logic [DATA_W-1:0] dl_data_q [LATENCY];

    logic [TAG_W-1:0]  out_tag_q,  out_tag_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [IDX_W-1:0]  word_idx;
    logic [TAG_W-1:0]  alloc_tag;
    logic [TAG_W-1:0]  done_tag;
    logic              req;
    logic              load_acc;
    logic              store_acc;
    logic              unused_addr;

    assign word_idx    = proc2mem_addr[3 +: IDX_W];
    assign unused_addr = ^{proc2mem_addr[2:0], proc2mem_addr[ADDR_W-1:3+IDX_W]};

    assign req       = is_cmd_active(proc2mem_command) && !reset;
    assign load_acc  = (alloc_tag != '0) && (proc2mem_command == BUS_LOAD);
    assign store_acc = (alloc_tag != '0) && (proc2mem_command == BUS_STORE);
    assign done_tag  = dl_tag_q[LATENCY-1];

    mem_tag_alloc u_tag_alloc (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
        .set_i     (load_acc),
        .clr_tag_i (done_tag),
        .tag_o     (alloc_tag)
    );

    assign mem2proc_response = alloc_tag;
    assign mem2proc_tag      = out_tag_q;
    assign mem2proc_data     = out_data_q;

    // Storage array: written only by accepted stores, never reset.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            mem_q[word_idx] <= proc2mem_data;
        end
    end

    // Delay line: stage 0 captures the load tag and word snapshot at acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                dl_tag_q[i]  <= '0;
                dl_data_q[i] <= '0;
            end
        end else begin
            dl_tag_q[0]  <= load_acc ? alloc_tag : '0;
            dl_data_q[0] <= mem_q[word_idx];
            for (int i = 1; i < LATENCY; i++) begin
                dl_tag_q[i]  <= dl_tag_q[i-1];
                dl_data_q[i] <= dl_data_q[i-1];
            end
        end
    end

    // Return-port next state: present a completion for one cycle, hold data otherwise.
    always_comb begin
        out_tag_d  = done_tag;
        out_data_d = out_data_q;
        if (done_tag != '0) begin
            out_data_d = dl_data_q[LATENCY-1];
        end
    end

    // Return-port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_tag_q  <= '0;
            out_data_q <= '0;
        end else begin
            out_tag_q  <= out_tag_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_tagged_mem.sv
// Self-checking bench for tagged_mem against a transaction-level reference model.
module tb_tagged_mem;
    import mem_bus_pkg::*;

    localparam int LAT       = 10;
    localparam int MEM_WORDS = 8192;

    logic        clk;
    logic        reset;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [1:0]  proc2mem_command;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    tagged_mem #(.LATENCY(LAT), .MEM_WORDS(MEM_WORDS)) dut (
        .clk               (clk),
        .reset             (reset),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .proc2mem_command  (proc2mem_command),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: sparse memory, per-tag busy flags, queue of pending returns.
    typedef struct {
        int          due;
        int          tag;
        logic [63:0] data;
        bit          known;
    } pend_t;

    logic [63:0] mem_m [int];
    bit          busy_m [16];
    pend_t       pend_q [$];
    int          edge_n    = 0;
    int          exp_tag   = 0;
    logic [63:0] exp_data  = '0;
    bit          exp_known = 1'b0;

    task automatic step(input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [63:0] data, input bit rst);
        int    exp_resp;
        int    idx;
        pend_t p;
        @(negedge clk);
        proc2mem_command = cmd;
        proc2mem_addr    = addr;
        proc2mem_data    = data;
        reset            = rst;
        #1;
        exp_resp = 0;
        if (!rst && (cmd == 2'd1 || cmd == 2'd2)) begin
            for (int t = 15; t >= 1; t--) begin
                if (!busy_m[t]) exp_resp = t;
            end
        end
        check_val("response", 64'(mem2proc_response), 64'(exp_resp));
        idx = int'((addr >> 3) % MEM_WORDS);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int t = 0; t < 16; t++) busy_m[t] = 1'b0;
            pend_q.delete();
            exp_tag   = 0;
            exp_data  = '0;
            exp_known = 1'b1;
        end else begin
            exp_tag = 0;
            if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
                p = pend_q.pop_front();
                exp_tag   = p.tag;
                exp_data  = p.data;
                exp_known = p.known;
                busy_m[p.tag] = 1'b0;
            end
            if (exp_resp != 0) begin
                if (cmd == 2'd2) begin
                    mem_m[idx] = data;
                end else begin
                    busy_m[exp_resp] = 1'b1;
                    p.due   = edge_n + LAT;
                    p.tag   = exp_resp;
                    p.known = mem_m.exists(idx);
                    p.data  = p.known ? mem_m[idx] : '0;
                    pend_q.push_back(p);
                end
            end
        end
        edge_n++;
        check_val("ret_tag", 64'(mem2proc_tag), 64'(exp_tag));
        if (exp_known) check_val("ret_data", mem2proc_data, exp_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'd0, 32'h0, 64'h0, 1'b0);
    endtask

    initial begin
        reset            = 1'b1;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_command = '0;

        step(2'd0, 32'h0, 64'h0, 1'b1);
        step(2'd1, 32'h0, 64'h0, 1'b1);

        // Two stores then two loads of the same words.
        step(2'd2, 32'h0, 64'd233, 1'b0);
        step(2'd2, 32'h8, 64'd666, 1'b0);
        step(2'd1, 32'h0, 64'h0, 1'b0);
        step(2'd1, 32'h8, 64'h0, 1'b0);
        idle(LAT + 2);

        // Byte offsets inside one word alias to that word.
        step(2'd2, 32'h0, 64'd233, 1'b0);
        step(2'd2, 32'h4, 64'd996, 1'b0);
        step(2'd1, 32'h0, 64'h0, 1'b0);
        step(2'd1, 32'h4, 64'h0, 1'b0);
        idle(LAT + 2);

        // Store between two loads of the same word.
        step(2'd1, 32'h8, 64'h0, 1'b0);
        step(2'd2, 32'h8, 64'd777, 1'b0);
        step(2'd1, 32'h8, 64'h0, 1'b0);
        idle(LAT + 2);

        // NONE and reserved commands must not write.
        step(2'd2, 32'h10, 64'd5, 1'b0);
        step(2'd0, 32'h10, 64'd99, 1'b0);
        step(2'd3, 32'h10, 64'd98, 1'b0);
        step(2'd1, 32'h10, 64'h0, 1'b0);
        idle(LAT + 2);

        // Reset drops in-flight loads.
        step(2'd1, 32'h0, 64'h0, 1'b0);
        step(2'd1, 32'h8, 64'h0, 1'b0);
        step(2'd1, 32'h10, 64'h0, 1'b0);
        idle(2);
        step(2'd0, 32'h0, 64'h0, 1'b1);
        idle(LAT + 3);
        step(2'd1, 32'h8, 64'h0, 1'b0);
        idle(LAT + 2);

        // Continuous loads: tags recycle after completion.
        for (int i = 0; i < 20; i++) step(2'd1, 32'(i * 8), 64'h0, 1'b0);
        idle(LAT + 2);

        // Seed a small working set, then randomized traffic over it.
        for (int i = 0; i < 16; i++) step(2'd2, 32'(i * 8), {$urandom(), $urandom()}, 1'b0);
        for (int i = 0; i < 800; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 15)) << 3) | 32'($urandom_range(0, 7))
                | ($urandom() & 32'hFFFF_0000);
            step(2'($urandom_range(0, 3)), a, {$urandom(), $urandom()},
                 ($urandom_range(0, 99) == 0));
        end
        idle(LAT + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
